npu_cube_mac_acc_pipe: RTL and testbench
========================================

# npu_cube_mac_acc_pipe

Pipelined, parametrised successor to the NPU cube add tree. Each beat forms MAC_NUM DWA×DWB products and reduces them through a carry-save tree. The sum/carry pair is registered, resolved with one carry-propagate add, and accumulated over a multi-beat group (first/last framing). Optional saturation is supported. The block sits between the cube operand fetch and the output/requant stage, and delivers one accumulated dot product per group.

## Interface
- DWA, 8, data operand width per MAC lane
- DWB, 8, parameter operand width per MAC lane
- MAC_NUM, 8, lanes per beat; power of two, ≥2
- DWACC, 32, accumulator/output width; must be ≥ DWP
- Derived DWP = DWA+DWB+log2(MAC_NUM), the dot-product width (19 at defaults)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- is_signed  in  1  1 = both operands two's complement; 0 = both unsigned; sampled per beat
- sat_en  in  1  1 = clamp accumulator on overflow; 0 = wrap modulo 2^DWACC; sampled per beat
- in_valid  in  1  beat present
- in_first  in  1  beat starts a new group (qualified by in_valid)
- in_last  in  1  beat ends the group (qualified by in_valid)
- in_data  in  DWA*MAC_NUM  lane i at [DWA*i +: DWA]
- in_para  in  DWB*MAC_NUM  lane i at [DWB*i +: DWB]
- out_valid  out  1  one-cycle pulse, group result valid
- out_data  out  DWACC  accumulated group result
- out_sat  out  1  ≥1 clamp occurred in this group; valid with out_valid

## Operation
- No backpressure; the block accepts one beat per cycle.
- S1 (registered):
  - Per lane, product = data×para, sign- or zero-extended per is_signed.
  - The MAC_NUM products are reduced by a CSA (3:2/4:2) tree to a sum/carry pair of DWP bits.
  - Registers: s1_sum, s1_carry, s1_valid, s1_first, s1_last, s1_signed, s1_sat_en.
- S2 (registered):
  - dot = (s1_sum + s1_carry) mod 2^DWP, interpreted as signed if s1_signed, else unsigned.
  - dot is extended to DWACC+1 bits.
  - base = 0 if s1_first, else acc.
  - raw = base + dot, computed at DWACC+1 bits.
- Overflow and clamping:
  - Signed overflow: raw is outside [-2^(DWACC-1), 2^(DWACC-1)-1].
  - Unsigned overflow: raw ≥ 2^DWACC.
  - If sat_en and overflow, acc ← the violated bound and sat_sticky ← 1. Otherwise acc ← raw mod 2^DWACC.
  - sat_sticky is cleared on s1_first (then set by the current beat's clamp).
- On an S2 beat with s1_last:
  - out_valid ← 1, out_data ← new acc value, out_sat ← updated sticky.
  - acc and sat_sticky ← 0, so a following beat without in_first starts from zero.
- in_first and in_last together form a single-beat group.
- A beat with in_first in the middle of a group restarts the group; the partial sum is discarded and nothing is output.
- in_valid low: bubble; acc, sat_sticky and out_data hold.
- Mixing is_signed within a group is legal; each beat's dot uses its own mode.

## Timing
- Latency: beat with in_last at cycle N → out_valid high at cycle N+2.
- Throughput: 1 beat/cycle. Back-to-back single-beat groups give out_valid every cycle.
- out_valid is high for exactly one cycle per group. out_data/out_sat hold their last value when out_valid is low.
- Reset (rst high at an edge):
  - s1_valid, acc, sat_sticky, out_valid, out_data, out_sat ← 0.
  - In-flight beats are dropped and produce no out_valid.
  - Beats presented while rst is high are ignored.
- First beat accepted: the one presented at the first edge with rst low.

## Test plan
- Unsigned single beat, defaults: all lanes 255×255, first=last=1 → out_data=520200 at N+2, out_sat=0.
- Signed single beat: all lanes -128×-128 → 131072. Then all lanes -128×127 → -130048 (0xFFFE_0400).
- 4-beat group, data=1, para=lane index (0..7), unsigned → out_data=112. A 1-cycle in_valid gap mid-group gives the same result and latency.
- DWACC=20, unsigned, 3 beats of 520200:
  - sat_en=1 → out_data=1048575, out_sat=1.
  - sat_en=0 → out_data=512024, out_sat=0.
- DWACC=20, signed, sat_en=1, 5 beats of 131072 → 524287, out_sat=1. The next group (1 beat, 1×1 lane 0 only) → 1, out_sat=0.
- rst asserted for 1 cycle with two beats in flight → no out_valid, all outputs 0. A new group issued after reset is correct.

Source files
------------

// File: rtl/npu_cube_mac_acc_pipe.sv
// npu_cube_mac_acc_pipe
// Two-stage MAC/accumulate pipeline. S1 forms MAC_NUM lane products and
// reduces them through a 4:2 carry-save tree to a sum/carry pair. S2 resolves
// the pair with one carry-propagate add and accumulates it over a first/last
// framed group, with optional clamping on overflow. One result per group.
module npu_cube_mac_acc_pipe #(
    parameter int DWA     = 8,
    parameter int DWB     = 8,
    parameter int MAC_NUM = 8,
    parameter int DWACC   = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     is_signed_i,
    input  logic                     sat_en_i,
    input  logic                     in_valid_i,
    input  logic                     in_first_i,
    input  logic                     in_last_i,
    input  logic [DWA*MAC_NUM-1:0]   in_data_i,
    input  logic [DWB*MAC_NUM-1:0]   in_para_i,
    output logic                     out_valid_o,
    output logic [DWACC-1:0]         out_data_o,
    output logic                     out_sat_o
);

    localparam int DWP = DWA + DWB + $clog2(MAC_NUM);
    localparam int NL  = MAC_NUM / 2;

    // 3:2 compressor: returns {sum, carry<<1}, both truncated to DWP bits
    function automatic logic [2*DWP-1:0] csa3(input logic [DWP-1:0] a,
                                             input logic [DWP-1:0] b,
                                             input logic [DWP-1:0] c);
        logic [DWP-1:0] maj;
        maj = (a & b) | (a & c) | (b & c);
        return {a ^ b ^ c, maj << 1};
    endfunction

    logic [DWP-1:0] prod [MAC_NUM];

    // Lane products at DWP bits; two's complement wraps correctly mod 2^DWP
    for (genvar i = 0; i < MAC_NUM; i++) begin : g_lane
        logic [DWP-1:0] a_ext;
        logic [DWP-1:0] b_ext;
        assign a_ext = {{(DWP-DWA){is_signed_i & in_data_i[DWA*i+DWA-1]}},
                        in_data_i[DWA*i +: DWA]};
        assign b_ext = {{(DWP-DWB){is_signed_i & in_para_i[DWB*i+DWB-1]}},
                        in_para_i[DWB*i +: DWB]};
        assign prod[i] = a_ext * b_ext;
    end

    // Heap-ordered tree: node k holds a sum/carry pair, leaves pair up two
    // products, internal nodes merge two child pairs with a 4:2 compressor.
    logic [DWP-1:0] ts [MAC_NUM];
    logic [DWP-1:0] tc [MAC_NUM];
    logic [DWP-1:0] xs;
    logic [DWP-1:0] xc;

    // Carry-save reduction of all lane products to one sum/carry pair
    always_comb begin
        ts = '{default: '0};
        tc = '{default: '0};
        xs = '0;
        xc = '0;
        for (int k = NL; k < MAC_NUM; k++) begin
            ts[k] = prod[2*(k-NL)];
            tc[k] = prod[2*(k-NL)+1];
        end
        for (int k = NL - 1; k >= 1; k--) begin
            {xs, xc}     = csa3(ts[2*k], tc[2*k], ts[2*k+1]);
            {ts[k], tc[k]} = csa3(xs, xc, tc[2*k+1]);
        end
    end

    logic [DWP-1:0] s1_sum_d, s1_carry_d;
    assign s1_sum_d   = ts[1];
    assign s1_carry_d = tc[1];

    logic [DWP-1:0] s1_sum_q, s1_carry_q;
    logic           s1_valid_q, s1_first_q, s1_last_q, s1_signed_q, s1_sat_en_q;

    // S1 register: compressed pair plus per-beat control
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_carry_q  <= '0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_signed_q <= 1'b0;
            s1_sat_en_q <= 1'b0;
        end else begin
            s1_valid_q  <= in_valid_i;
            s1_sum_q    <= s1_sum_d;
            s1_carry_q  <= s1_carry_d;
            s1_first_q  <= in_first_i;
            s1_last_q   <= in_last_i;
            s1_signed_q <= is_signed_i;
            s1_sat_en_q <= sat_en_i;
        end
    end

    logic [DWACC-1:0] acc_q, acc_d;
    logic             sticky_q, sticky_d;
    logic [DWP-1:0]   dot;
    logic [DWACC:0]   dot_ext, base, raw, bound;
    logic [DWACC-1:0] bound_w;
    logic             ovf, clamp;

    // S2 combinational: resolve dot, add to running sum, detect and clamp
    always_comb begin
        dot     = s1_sum_q + s1_carry_q;
        dot_ext = {{(DWACC+1-DWP){s1_signed_q & dot[DWP-1]}}, dot};
        // The held accumulator is reinterpreted in the current beat's mode
        base    = s1_first_q ? '0 : {s1_signed_q & acc_q[DWACC-1], acc_q};
        raw     = base + dot_ext;
        if (s1_signed_q) begin
            ovf   = raw[DWACC] ^ raw[DWACC-1];
            bound = raw[DWACC] ? {2'b11, {(DWACC-1){1'b0}}}
                               : {2'b00, {(DWACC-1){1'b1}}};
        end else begin
            ovf   = raw[DWACC];
            bound = {1'b0, {DWACC{1'b1}}};
        end
        bound_w  = bound[DWACC-1:0];
        clamp    = s1_sat_en_q & ovf;
        acc_d    = clamp ? bound_w : raw[DWACC-1:0];
        sticky_d = (s1_first_q ? 1'b0 : sticky_q) | clamp;
    end

    logic             out_valid_q, out_sat_q;
    logic [DWACC-1:0] out_data_q;

    // S2 register: accumulate, emit on last beat and clear for the next group
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            out_valid_q <= s1_valid_q & s1_last_q;
            if (s1_valid_q) begin
                if (s1_last_q) begin
                    out_data_q <= acc_d;
                    out_sat_q  <= sticky_d;
                    acc_q      <= '0;
                    sticky_q   <= 1'b0;
                end else begin
                    acc_q    <= acc_d;
                    sticky_q <= sticky_d;
                end
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_sat_o   = out_sat_q;

endmodule

// File: tb/tb_npu_cube_mac_acc_pipe.sv
// Bench for npu_cube_mac_acc_pipe: a default instance (DWACC=32) and a narrow
// instance (DWACC=20) share stimulus; an arithmetic model predicts both.
module tb_npu_cube_mac_acc_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_signed, sat_en, in_valid, in_first, in_last;
    logic [63:0] in_data, in_para;
    logic        ov0, os0, ov1, os1;
    logic [31:0] od0;
    logic [19:0] od1;

    always #5 clk = ~clk;

    npu_cube_mac_acc_pipe dut (
        .clk_i(clk), .rst_i(rst), .is_signed_i(is_signed), .sat_en_i(sat_en),
        .in_valid_i(in_valid), .in_first_i(in_first), .in_last_i(in_last),
        .in_data_i(in_data), .in_para_i(in_para),
        .out_valid_o(ov0), .out_data_o(od0), .out_sat_o(os0));

    npu_cube_mac_acc_pipe #(.DWACC(20)) dut20 (
        .clk_i(clk), .rst_i(rst), .is_signed_i(is_signed), .sat_en_i(sat_en),
        .in_valid_i(in_valid), .in_first_i(in_first), .in_last_i(in_last),
        .in_data_i(in_data), .in_para_i(in_para),
        .out_valid_o(ov1), .out_data_o(od1), .out_sat_o(os1));

    typedef struct {
        int     due;
        bit     vld;
        longint d0;
        bit     s0;
        longint d1;
        bit     s1;
    } ev_t;

    ev_t    evq[$];
    ev_t    cur_e;
    int     cyc = 0;
    int     last_cyc = 0;
    int     checks = 0;
    int     errors = 0;
    bit     chk_en = 1'b0;
    longint acc_m[2];
    bit     stk_m[2];
    bit     exp_v;
    longint exp_d0, exp_d1;
    bit     exp_s0, exp_s1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Group-level model: dot product as integer sum, accumulate, clamp at bounds
    task automatic model_beat(bit f, bit l, bit sg, bit st, logic [63:0] dv, logic [63:0] pv);
        longint dot, m, lo, hi, base, raw, val;
        ev_t e;
        dot = 0;
        for (int i = 0; i < 8; i++) begin
            logic [7:0] a, b;
            a = dv[8*i +: 8];
            b = pv[8*i +: 8];
            if (sg) dot += longint'($signed(a)) * longint'($signed(b));
            else    dot += longint'(a) * longint'(b);
        end
        e = '{due: cyc + 2, vld: 1'b1, d0: 0, s0: 1'b0, d1: 0, s1: 1'b0};
        for (int d = 0; d < 2; d++) begin
            m = longint'(1) << (d == 0 ? 32 : 20);
            if (f) begin
                acc_m[d] = 0;
                stk_m[d] = 1'b0;
            end
            base = acc_m[d];
            if (sg && base >= m / 2) base -= m;
            raw = base + dot;
            lo  = sg ? -(m / 2) : 0;
            hi  = sg ? (m / 2 - 1) : (m - 1);
            if (st && raw > hi) begin
                val = hi;
                stk_m[d] = 1'b1;
            end else if (st && raw < lo) begin
                val = ((lo % m) + m) % m;
                stk_m[d] = 1'b1;
            end else begin
                val = ((raw % m) + m) % m;
            end
            if (l) begin
                if (d == 0) begin e.d0 = val; e.s0 = stk_m[d]; end
                else        begin e.d1 = val; e.s1 = stk_m[d]; end
                acc_m[d] = 0;
                stk_m[d] = 1'b0;
            end else begin
                acc_m[d] = val;
            end
        end
        if (l) evq.push_back(e);
    endtask

    task automatic drive(bit v, bit f, bit l, bit sg, bit st, logic [63:0] dv, logic [63:0] pv);
        @(posedge clk);
        #1;
        in_valid = v; in_first = f; in_last = l;
        is_signed = sg; sat_en = st;
        in_data = dv; in_para = pv;
        if (v && !rst) model_beat(f, l, sg, st, dv, pv);
        if (v) last_cyc = cyc;
    endtask

    task automatic tx(bit f, bit l, bit sg, bit st, logic [63:0] dv, logic [63:0] pv);
        drive(1'b1, f, l, sg, st, dv, pv);
    endtask

    task automatic idl();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    // One-cycle reset while a beat is also presented; in-flight results are lost
    task automatic rst_pulse();
        int k;
        @(posedge clk);
        #1;
        k = cyc;
        rst = 1'b1;
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1;
        in_data = {8{8'h05}}; in_para = {8{8'h05}};
        while (evq.size() > 0 && evq[$].due > k) void'(evq.pop_back());
        evq.push_back('{due: k + 1, vld: 1'b0, d0: 0, s0: 1'b0, d1: 0, s1: 1'b0});
        acc_m = '{0, 0};
        stk_m = '{1'b0, 1'b0};
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    // Hand-computed expectation at the negedge of cycle tgt
    task automatic lit(string nm, int tgt, logic v, logic [31:0] d0, logic s0,
                       logic [19:0] d1, logic s1);
        int g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (cyc < tgt && g < 200);
        chk({nm, "_cycle"}, 64'(cyc), 64'(tgt));
        chk({nm, "_vld32"}, 64'(ov0), 64'(v));
        chk({nm, "_dat32"}, 64'(od0), 64'(d0));
        chk({nm, "_sat32"}, 64'(os0), 64'(s0));
        chk({nm, "_vld20"}, 64'(ov1), 64'(v));
        chk({nm, "_dat20"}, 64'(od1), 64'(d1));
        chk({nm, "_sat20"}, 64'(os1), 64'(s1));
    endtask

    // Every-cycle comparison against the model's scheduled results
    always @(negedge clk) begin
        if (chk_en) begin
            exp_v = 1'b0;
            if (evq.size() > 0 && evq[0].due == cyc) begin
                cur_e  = evq.pop_front();
                exp_v  = cur_e.vld;
                exp_d0 = cur_e.d0; exp_s0 = cur_e.s0;
                exp_d1 = cur_e.d1; exp_s1 = cur_e.s1;
            end
            chk("m_vld32", 64'(ov0), 64'(exp_v));
            chk("m_dat32", 64'(od0), exp_d0);
            chk("m_sat32", 64'(os0), 64'(exp_s0));
            chk("m_vld20", 64'(ov1), 64'(exp_v));
            chk("m_dat20", 64'(od1), exp_d1);
            chk("m_sat20", 64'(os1), 64'(exp_s1));
        end
    end

    initial begin
        rst = 1'b1;
        is_signed = 1'b0; sat_en = 1'b0;
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_data = '0; in_para = '0;
        acc_m = '{0, 0};
        stk_m = '{1'b0, 1'b0};
        exp_d0 = 0; exp_d1 = 0; exp_s0 = 1'b0; exp_s1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        lit("reset", cyc, 1'b0, 32'd0, 1'b0, 20'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // unsigned 255x255 on all lanes
        tx(1, 1, 0, 0, {8{8'hFF}}, {8{8'hFF}});
        idl();
        lit("u_max", last_cyc + 2, 1'b1, 32'd520200, 1'b0, 20'd520200, 1'b0);

        // signed -128x-128, then -128x127
        tx(1, 1, 1, 0, {8{8'h80}}, {8{8'h80}});
        idl();
        lit("s_pos", last_cyc + 2, 1'b1, 32'd131072, 1'b0, 20'd131072, 1'b0);
        tx(1, 1, 1, 0, {8{8'h80}}, {8{8'h7F}});
        idl();
        lit("s_neg", last_cyc + 2, 1'b1, 32'hFFFE_0400, 1'b0, 20'hE_0400, 1'b0);

        // 4-beat group, data 1, para = lane index
        tx(1, 0, 0, 0, {8{8'h01}}, 64'h0706050403020100);
        tx(0, 0, 0, 0, {8{8'h01}}, 64'h0706050403020100);
        tx(0, 0, 0, 0, {8{8'h01}}, 64'h0706050403020100);
        tx(0, 1, 0, 0, {8{8'h01}}, 64'h0706050403020100);
        idl();
        lit("grp4", last_cyc + 2, 1'b1, 32'd112, 1'b0, 20'd112, 1'b0);

        // same group with a bubble in the middle
        tx(1, 0, 0, 0, {8{8'h01}}, 64'h0706050403020100);
        tx(0, 0, 0, 0, {8{8'h01}}, 64'h0706050403020100);
        idl();
        tx(0, 0, 0, 0, {8{8'h01}}, 64'h0706050403020100);
        tx(0, 1, 0, 0, {8{8'h01}}, 64'h0706050403020100);
        idl();
        lit("grp4_gap", last_cyc + 2, 1'b1, 32'd112, 1'b0, 20'd112, 1'b0);

        // unsigned overflow of the narrow accumulator, clamped then wrapped
        for (int r = 0; r < 2; r++) begin
            tx(1, 0, 0, r == 0, {8{8'hFF}}, {8{8'hFF}});
            tx(0, 0, 0, r == 0, {8{8'hFF}}, {8{8'hFF}});
            tx(0, 1, 0, r == 0, {8{8'hFF}}, {8{8'hFF}});
            idl();
            if (r == 0) lit("u_sat", last_cyc + 2, 1'b1, 32'd1560600, 1'b0, 20'd1048575, 1'b1);
            else        lit("u_wrap", last_cyc + 2, 1'b1, 32'd1560600, 1'b0, 20'd512024, 1'b0);
        end

        // signed overflow with clamp, then a clean group clears the sticky
        tx(1, 0, 1, 1, {8{8'h80}}, {8{8'h80}});
        for (int b = 0; b < 3; b++) tx(0, 0, 1, 1, {8{8'h80}}, {8{8'h80}});
        tx(0, 1, 1, 1, {8{8'h80}}, {8{8'h80}});
        idl();
        lit("s_sat", last_cyc + 2, 1'b1, 32'd655360, 1'b0, 20'd524287, 1'b1);
        tx(1, 1, 1, 1, 64'h01, 64'h01);
        idl();
        lit("s_after", last_cyc + 2, 1'b1, 32'd1, 1'b0, 20'd1, 1'b0);

        // back-to-back single-beat groups, a restart mid-group, a group
        // continuing from zero without in_first, and mixed signedness
        tx(1, 1, 0, 0, {8{8'h03}}, {8{8'h07}});
        tx(1, 1, 1, 0, {8{8'hFE}}, {8{8'h05}});
        tx(1, 1, 0, 1, {8{8'h10}}, {8{8'h20}});
        tx(1, 0, 0, 0, {8{8'h40}}, {8{8'h40}});
        tx(1, 0, 0, 0, {8{8'h02}}, {8{8'h02}});
        tx(0, 1, 1, 0, {8{8'hFF}}, {8{8'h01}});
        tx(0, 1, 0, 0, {8{8'h02}}, {8{8'h03}});
        tx(1, 0, 1, 1, {8{8'h80}}, {8{8'h7F}});
        tx(0, 1, 0, 1, {8{8'h01}}, {8{8'h01}});
        idl();
        idl();
        idl();

        // reset with two beats of a group in flight
        tx(1, 0, 0, 0, {8{8'h11}}, {8{8'h22}});
        tx(0, 1, 0, 0, {8{8'h11}}, {8{8'h22}});
        rst_pulse();
        lit("rst_flush", cyc, 1'b0, 32'd0, 1'b0, 20'd0, 1'b0);
        lit("rst_hold", cyc + 1, 1'b0, 32'd0, 1'b0, 20'd0, 1'b0);
        tx(1, 1, 0, 0, {8{8'hFF}}, {8{8'hFF}});
        idl();
        lit("post_rst", last_cyc + 2, 1'b1, 32'd520200, 1'b0, 20'd520200, 1'b0);

        repeat (4) idl();
        chk("model_drained", 64'(evq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
